dev_dumper: RTL and testbench
=============================

Name: dev_dumper

Overview:
Reads a contiguous RAM region byte by byte and emits it as an ASCII hex character stream for the UART transmit path. It is the reverse of the hex loader, and its output format is one the loader accepts unchanged. Bytes are printed as two uppercase hex digits, separated by spaces and broken into lines. The stream ends with 0x04 (EOT), so a dump fed back into the loader reproduces the memory image.

Parameters:
ADDRW, pkg_ram::RAM_ADDRW, RAM byte-address width
RD_LAT, 1, RAM read latency in cycles (>=1)
BYTES_PER_LINE, 16, bytes printed per output line (>=1)

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-low
start  in  1  one-cycle request; sampled only in IDLE
start_addr  in  ADDRW  first byte address
count  in  ADDRW+1  number of bytes to dump (0 allowed)
ram_rd  out  1  one-cycle RAM byte read strobe
ram_addr  out  ADDRW  read address, valid while ram_rd=1
ram_rdata  in  pkg_ram::RAM_BYTE  read data, valid RD_LAT cycles after ram_rd
tx_data  out  8  ASCII character
tx_valid  out  1  tx_data valid
tx_ready  in  1  sink accepts the character when tx_valid&&tx_ready at a rising edge
busy  out  1  high from start acceptance until EOT is accepted
done  out  1  sticky; set when EOT is accepted, cleared on next accepted start

Behaviour:
- Clocking and reset: one clock domain, clk. Reset is asynchronous and active-low (rst=0). Asserting reset forces:
  - all outputs to 0;
  - state to IDLE;
  - internal address, byte counter and line counter to 0.
- Reset mid-dump aborts immediately. No further characters are emitted, and no done is raised.
- States: IDLE, READ, WAIT, HI, LO, SEP, EOL, EOT.
- IDLE:
  - start=1 latches start_addr and count, clears the line counter, clears done, and sets busy.
  - Next state is READ if count!=0, otherwise EOT.
  - start in any other state is ignored.
- READ:
  - ram_rd=1 with ram_addr equal to the current address for exactly one cycle.
  - Next state is WAIT.
- WAIT:
  - Counts RD_LAT cycles, then captures ram_rdata into a byte register.
  - Then increments the address, modulo 2^ADDRW (wraps from all-ones to 0), and decrements the remaining count.
  - Next state is HI.
- HI and LO:
  - HI drives tx_valid=1 with tx_data equal to the ASCII of the upper nibble; LO does the same for the lower nibble.
  - Encoding: nibble 0-9 maps to 0x30-0x39; 10-15 maps to 0x41-0x46.
  - Each state advances only on handshake.
- After LO is accepted, the line counter increments:
  - if remaining==0 or line counter==BYTES_PER_LINE, go to EOL;
  - otherwise go to SEP.
- SEP: emits 0x20, then goes to READ.
- EOL:
  - emits 0x0A and clears the line counter;
  - then goes to READ if remaining!=0, else to EOT.
- EOT: emits 0x04. On handshake, sets done=1, clears busy, and returns to IDLE.
- Output handshake rules:
  - tx_valid and tx_data are registered.
  - Once tx_valid=1, tx_data stays stable and tx_valid stays high until accepted; tx_ready may be held low indefinitely.
  - tx_valid is never asserted in IDLE, READ or WAIT.
  - Back-to-back characters are allowed: tx_valid stays high across HI->LO->SEP when tx_ready=1.
- Latency:
  - Start acceptance edge -> ram_rd high in the next cycle.
  - First tx_valid appears RD_LAT+1 cycles after ram_rd.
- Count range: count equal to 2^ADDRW dumps the whole memory once, and the counter has no overflow.

Test Plan:
- Basic dump: mem[0x10..0x12]=00,AB,7F; start_addr=0x10, count=3, tx_ready=1 -> exactly 30 30 20 41 42 20 37 46 0A 04. Then done=1 and busy=0.
- Line break: BYTES_PER_LINE=2, same data -> 30 30 20 41 42 0A 37 46 0A 04.
- Empty dump: count=0 -> single 0x04 with no ram_rd pulse, and done=1.
- Backpressure: tx_ready low for 5 cycles on each character, with random stalls -> identical character sequence. tx_data stays stable while tx_valid&&!tx_ready, and nothing is dropped or duplicated.
- Address wrap and latency: start_addr=all-ones, count=2, RD_LAT=3 -> ram_addr=all-ones then 0. Each byte is captured 3 cycles after its ram_rd.
- Reset and restart:
  - rst=0 after the 4th character -> all outputs 0 asynchronously, and no further characters.
  - A new start after release dumps correctly.
  - start pulsed while busy has no effect.
- Round trip: the dump output is fed into the hex loader, and the reloaded RAM matches the original region byte for byte.

Source files
------------

// File: rtl/dev_dumper.sv
// RAM-to-ASCII hex dumper: streams a byte region as "HH HH ...\n" lines ending in EOT (0x04),
// in the same text format the hex loader reads back in.
package pkg_ram;
  localparam int RAM_ADDRW = 8;
  typedef logic [7:0] RAM_BYTE;
endpackage

module dev_dumper #(
  parameter int ADDRW          = pkg_ram::RAM_ADDRW,
  parameter int RD_LAT         = 1,
  parameter int BYTES_PER_LINE = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDRW-1:0]  start_addr,
  input  logic [ADDRW:0]    count,
  output logic              ram_rd,
  output logic [ADDRW-1:0]  ram_addr,
  input  pkg_ram::RAM_BYTE  ram_rdata,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic              done
);

  localparam int LW = $clog2(BYTES_PER_LINE + 1);
  localparam int WW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [LW-1:0]    BPL    = LW'(BYTES_PER_LINE);
  localparam logic [WW-1:0]    WLAST  = WW'(RD_LAT - 1);
  localparam logic [ADDRW-1:0] A_ONE  = 1;
  localparam logic [ADDRW:0]   R_ONE  = 1;
  localparam logic [LW-1:0]    L_ONE  = 1;
  localparam logic [WW-1:0]    W_ONE  = 1;

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_WAIT, S_HI, S_LO, S_SEP, S_EOL, S_EOT
  } state_t;

  state_t           state_q, state_d;
  logic [ADDRW-1:0] addr_q, addr_d;
  logic [ADDRW:0]   remain_q, remain_d;
  logic [LW-1:0]    line_q, line_d;
  logic [WW-1:0]    wait_q, wait_d;
  logic [3:0]       lo_nib_q, lo_nib_d;
  logic [7:0]       txd_q, txd_d;
  logic             txv_q, txv_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             hs;
  logic [LW-1:0]    line_inc;

  function automatic logic [7:0] hex_char(input logic [3:0] nib);
    return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
  endfunction

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    remain_d = remain_q;
    line_d   = line_q;
    wait_d   = wait_q;
    lo_nib_d = lo_nib_q;
    txd_d    = txd_q;
    txv_d    = txv_q;
    busy_d   = busy_q;
    done_d   = done_q;
    hs       = txv_q && tx_ready;
    line_inc = line_q + L_ONE;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d   = start_addr;
          remain_d = count;
          line_d   = '0;
          done_d   = 1'b0;
          busy_d   = 1'b1;
          if (count != '0) begin
            state_d = S_READ;
          end else begin
            state_d = S_EOT;
            txv_d   = 1'b1;
            txd_d   = 8'h04;
          end
        end
      end
      S_READ: begin
        wait_d  = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // Only the low nibble needs keeping; the high one goes straight out as HI.
        if (wait_q == WLAST) begin
          lo_nib_d = ram_rdata[3:0];
          txd_d    = hex_char(ram_rdata[7:4]);
          txv_d    = 1'b1;
          addr_d   = addr_q + A_ONE;
          remain_d = remain_q - R_ONE;
          state_d  = S_HI;
        end else begin
          wait_d = wait_q + W_ONE;
        end
      end
      S_HI: begin
        if (hs) begin
          txd_d   = hex_char(lo_nib_q);
          state_d = S_LO;
        end
      end
      S_LO: begin
        if (hs) begin
          line_d = line_inc;
          if (remain_q == '0 || line_inc == BPL) begin
            txd_d   = 8'h0A;
            state_d = S_EOL;
          end else begin
            txd_d   = 8'h20;
            state_d = S_SEP;
          end
        end
      end
      S_SEP: begin
        if (hs) begin
          txv_d   = 1'b0;
          state_d = S_READ;
        end
      end
      S_EOL: begin
        if (hs) begin
          line_d = '0;
          if (remain_q != '0) begin
            txv_d   = 1'b0;
            state_d = S_READ;
          end else begin
            txd_d   = 8'h04;
            state_d = S_EOT;
          end
        end
      end
      S_EOT: begin
        if (hs) begin
          txv_d   = 1'b0;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      remain_q <= '0;
      line_q   <= '0;
      wait_q   <= '0;
      lo_nib_q <= '0;
      txd_q    <= '0;
      txv_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      remain_q <= remain_d;
      line_q   <= line_d;
      wait_q   <= wait_d;
      lo_nib_q <= lo_nib_d;
      txd_q    <= txd_d;
      txv_q    <= txv_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign ram_rd   = (state_q == S_READ);
  assign ram_addr = ram_rd ? addr_q : '0;
  assign tx_data  = txd_q;
  assign tx_valid = txv_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_dev_dumper.sv
// Bench for dev_dumper: two instances (different line length / read latency) checked every cycle
// against a text-level dump model, plus literal streams and a loader round trip.
module tb_dev_dumper;
  localparam int AW   = pkg_ram::RAM_ADDRW;
  localparam int NCH  = 2;
  localparam int LAT0 = 1;
  localparam int LAT1 = 3;
  localparam int BPL0 = 16;
  localparam int BPL1 = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst;
  logic [1:0]           start, ram_rd, tx_valid, tx_ready, busy, done;
  logic [1:0][AW-1:0]   start_addr, ram_addr;
  logic [1:0][AW:0]     count;
  logic [1:0][7:0]      ram_rdata, tx_data;

  logic [7:0] mem  [0:(1<<AW)-1];
  logic [7:0] mem2 [0:(1<<AW)-1];
  logic [7:0] pipe0 [0:LAT0-1];
  logic [7:0] pipe1 [0:LAT1-1];

  dev_dumper #(.RD_LAT(LAT0), .BYTES_PER_LINE(BPL0)) dut0 (
    .clk(clk), .rst(rst), .start(start[0]), .start_addr(start_addr[0]), .count(count[0]),
    .ram_rd(ram_rd[0]), .ram_addr(ram_addr[0]), .ram_rdata(ram_rdata[0]),
    .tx_data(tx_data[0]), .tx_valid(tx_valid[0]), .tx_ready(tx_ready[0]),
    .busy(busy[0]), .done(done[0]));

  dev_dumper #(.RD_LAT(LAT1), .BYTES_PER_LINE(BPL1)) dut1 (
    .clk(clk), .rst(rst), .start(start[1]), .start_addr(start_addr[1]), .count(count[1]),
    .ram_rd(ram_rd[1]), .ram_addr(ram_addr[1]), .ram_rdata(ram_rdata[1]),
    .tx_data(tx_data[1]), .tx_valid(tx_valid[1]), .tx_ready(tx_ready[1]),
    .busy(busy[1]), .done(done[1]));

  // RAM models: data appears exactly RD_LAT cycles after the strobe, junk at all other times
  always @(posedge clk) begin
    pipe0[0] <= ram_rd[0] ? mem[ram_addr[0]] : 8'($urandom);
    for (int i = 1; i < LAT0; i++) pipe0[i] <= pipe0[i-1];
    pipe1[0] <= ram_rd[1] ? mem[ram_addr[1]] : 8'($urandom);
    for (int i = 1; i < LAT1; i++) pipe1[i] <= pipe1[i-1];
  end
  assign ram_rdata[0] = pipe0[LAT0-1];
  assign ram_rdata[1] = pipe1[LAT1-1];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // Expected streams from the text-level model
  logic [7:0]    exp_c [NCH][0:1023];
  logic [AW-1:0] exp_a [NCH][0:1023];
  logic [7:0]    got_c [NCH][0:1023];
  int exp_n [NCH], exp_p [NCH], expa_n [NCH], expa_p [NCH], got_n [NCH];
  string digits = "0123456789ABCDEF";

  task automatic push_c(input int ch, input logic [7:0] c);
    exp_c[ch][exp_n[ch]] = c;
    exp_n[ch]++;
  endtask

  task automatic model_dump(input int ch, input int sa, input int cnt, input int bpl);
    int line;
    logic [AW-1:0] a;
    logic [7:0] b;
    line = 0;
    exp_n[ch] = 0; exp_p[ch] = 0; expa_n[ch] = 0; expa_p[ch] = 0; got_n[ch] = 0;
    for (int i = 0; i < cnt; i++) begin
      a = AW'(sa + i);
      exp_a[ch][expa_n[ch]] = a;
      expa_n[ch]++;
      b = mem[a];
      push_c(ch, digits[b[7:4]]);
      push_c(ch, digits[b[3:0]]);
      line++;
      if (i == cnt - 1 || line == bpl) begin
        push_c(ch, 8'h0A);
        line = 0;
      end else begin
        push_c(ch, 8'h20);
      end
    end
    push_c(ch, 8'h04);
  endtask

  // Per-cycle compare against the model
  logic pv [NCH];
  logic pr [NCH];
  logic [7:0] pd [NCH];
  bit pend [NCH];
  int rd_cyc [NCH];
  int cyc = 0;

  initial begin
    for (int ch = 0; ch < NCH; ch++) begin pv[ch] = 0; pr[ch] = 0; pd[ch] = 0; pend[ch] = 0; rd_cyc[ch] = 0; end
    forever begin
      @(negedge clk);
      cyc++;
      for (int ch = 0; ch < NCH; ch++) begin
        if (!rst) begin
          pv[ch] = 0; pend[ch] = 0;
          continue;
        end
        if (pv[ch] && !pr[ch]) begin
          chk("hold_valid", 32'(tx_valid[ch]), 32'd1);
          chk("hold_data", 32'(tx_data[ch]), 32'(pd[ch]));
        end
        if (tx_valid[ch] && !pv[ch] && pend[ch]) begin
          chk("rd_to_valid", 32'(cyc - rd_cyc[ch]), 32'((ch == 0 ? LAT0 : LAT1) + 1));
          pend[ch] = 0;
        end
        if (ram_rd[ch]) begin
          chk("ram_addr", 32'(ram_addr[ch]),
              (expa_p[ch] < expa_n[ch]) ? 32'(exp_a[ch][expa_p[ch]]) : 32'h1_0000);
          expa_p[ch]++;
          rd_cyc[ch] = cyc;
          pend[ch] = 1;
        end
        if (tx_valid[ch] && tx_ready[ch]) begin
          chk("tx_char", 32'(tx_data[ch]),
              (exp_p[ch] < exp_n[ch]) ? 32'(exp_c[ch][exp_p[ch]]) : 32'h1_0000);
          exp_p[ch]++;
          if (got_n[ch] < 1024) got_c[ch][got_n[ch]] = tx_data[ch];
          got_n[ch]++;
        end
        pv[ch] = tx_valid[ch]; pr[ch] = tx_ready[ch]; pd[ch] = tx_data[ch];
      end
    end
  end

  // tx_ready driver: 0 = always ready, 1 = five low cycles per character, 2 = random stalls
  int rmode = 0;
  int stall [NCH];
  initial begin
    tx_ready = '0;
    stall[0] = 0; stall[1] = 0;
    forever begin
      @(posedge clk); #1;
      for (int ch = 0; ch < NCH; ch++) begin
        case (rmode)
          0: tx_ready[ch] = 1'b1;
          1: begin
            if (tx_valid[ch] && stall[ch] < 5) begin
              tx_ready[ch] = 1'b0; stall[ch]++;
            end else if (tx_valid[ch]) begin
              tx_ready[ch] = 1'b1; stall[ch] = 0;
            end else begin
              tx_ready[ch] = 1'b0;
            end
          end
          default: tx_ready[ch] = ($urandom_range(0, 2) == 0);
        endcase
      end
    end
  end

  task automatic run(input int ch, input int sa, input int cnt, input int bpl, input int budget, input bit glitch);
    int n;
    model_dump(ch, sa, cnt, bpl);
    @(posedge clk); #1;
    start[ch] = 1'b1; start_addr[ch] = AW'(sa); count[ch] = (AW+1)'(cnt);
    @(posedge clk); #1;
    start[ch] = 1'b0;
    chk("busy_after_start", 32'(busy[ch]), 32'd1);
    chk("rd_after_start", 32'(ram_rd[ch]), 32'(cnt != 0));
    chk("done_cleared", 32'(done[ch]), 32'd0);
    n = 0;
    while (!(done[ch] && !busy[ch]) && n < budget) begin
      @(posedge clk); #1;
      n++;
      if (glitch && n == 20) begin start[ch] = 1'b1; start_addr[ch] = 8'h55; count[ch] = 7; end
      if (glitch && n == 21) start[ch] = 1'b0;
    end
    chk("finish_in_budget", 32'(n < budget), 32'd1);
    chk("all_chars", 32'(exp_p[ch]), 32'(exp_n[ch]));
    chk("all_reads", 32'(expa_p[ch]), 32'(expa_n[ch]));
    chk("done_set", 32'(done[ch]), 32'd1);
    chk("busy_clear", 32'(busy[ch]), 32'd0);
  endtask

  task automatic chk_lit(input int ch, input string name, input int n, input logic [7:0] l [0:15]);
    chk({name, "_len"}, 32'(got_n[ch]), 32'(n));
    for (int i = 0; i < n; i++) chk(name, 32'(got_c[ch][i]), 32'(l[i]));
  endtask

  task automatic check_zero(input string name);
    for (int ch = 0; ch < NCH; ch++)
      chk(name, {6'd0, tx_valid[ch], busy[ch], done[ch], ram_rd[ch], ram_addr[ch], 6'd0, tx_data[ch]}, 32'd0);
  endtask

  logic [7:0] lit_a [0:15] = '{8'h30,8'h30,8'h20,8'h41,8'h42,8'h20,8'h37,8'h46,8'h0A,8'h04,0,0,0,0,0,0};
  logic [7:0] lit_b [0:15] = '{8'h30,8'h30,8'h20,8'h41,8'h42,8'h0A,8'h37,8'h46,8'h0A,8'h04,0,0,0,0,0,0};
  logic [7:0] lit_e [0:15] = '{8'h04,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0};
  logic [7:0] lit_w [0:15] = '{8'h43,8'h35,8'h20,8'h33,8'h45,8'h0A,8'h04,0,0,0,0,0,0,0,0,0};

  initial begin
    int n, nib, wa, loaded, diffs;
    logic [7:0] c, acc;
    rst = 1'b0; start = '0; start_addr = '0; count = '0;
    for (int i = 0; i < (1 << AW); i++) mem[i] = 8'(i * 37 + 11);
    mem[8'h10] = 8'h00; mem[8'h11] = 8'hAB; mem[8'h12] = 8'h7F;
    mem[8'hFF] = 8'hC5; mem[8'h00] = 8'h3E;
    #12;
    check_zero("reset_outputs");
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    rmode = 0;
    run(0, 8'h10, 3, BPL0, 300, 0);
    chk_lit(0, "basic_stream", 10, lit_a);
    run(1, 8'h10, 3, BPL1, 300, 0);
    chk_lit(1, "line_break_stream", 10, lit_b);
    run(0, 8'h00, 0, BPL0, 100, 0);
    chk_lit(0, "empty_stream", 1, lit_e);
    run(1, 8'hFF, 2, BPL1, 300, 0);
    chk_lit(1, "wrap_stream", 7, lit_w);

    rmode = 1;
    run(0, 8'h10, 3, BPL0, 2000, 1);
    chk_lit(0, "stall_stream", 10, lit_a);
    rmode = 2;
    run(1, 8'h20, 20, BPL1, 6000, 1);

    rmode = 0;
    run(0, 0, 1 << AW, BPL0, 6000, 0);
    chk("full_len", 32'(got_n[0]), 32'((1 << AW) * 3 + 1));
    // Hex loader: pairs of digits form bytes, spaces/newlines separate, EOT ends
    for (int i = 0; i < (1 << AW); i++) mem2[i] = 8'h00;
    nib = 0; wa = 0; loaded = 0; acc = 0;
    for (int i = 0; i < got_n[0] && i < 1024; i++) begin
      c = got_c[0][i];
      if (c == 8'h04) break;
      if (c >= "0" && c <= "9") begin acc = {acc[3:0], 4'(c - 8'h30)}; nib++; end
      else if (c >= "A" && c <= "F") begin acc = {acc[3:0], 4'(c - 8'h37)}; nib++; end
      if (nib == 2) begin mem2[wa] = acc; wa = (wa + 1) % (1 << AW); loaded++; nib = 0; end
    end
    diffs = 0;
    for (int i = 0; i < (1 << AW); i++) if (mem2[i] !== mem[i]) diffs++;
    chk("roundtrip_bytes", 32'(loaded), 32'(1 << AW));
    chk("roundtrip_diffs", 32'(diffs), 32'd0);

    model_dump(0, 8'h10, 3, BPL0);
    @(posedge clk); #1;
    start[0] = 1'b1; start_addr[0] = 8'h10; count[0] = 3;
    @(posedge clk); #1;
    start[0] = 1'b0;
    n = 0;
    while (got_n[0] < 4 && n < 500) begin @(posedge clk); #1; n++; end
    chk("reached_4th_char", 32'(got_n[0] >= 4), 32'd1);
    rst = 1'b0;
    #1;
    check_zero("async_abort_outputs");
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    n = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (tx_valid[0] || ram_rd[0] || busy[0] || done[0]) n++;
    end
    chk("quiet_after_abort", 32'(n), 32'd0);
    chk("chars_before_abort", 32'(got_n[0]), 32'd4);

    run(0, 8'h10, 3, BPL0, 300, 0);
    chk_lit(0, "restart_stream", 10, lit_a);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running required finished");
    $fatal(1, "timeout");
  end
endmodule
